seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blank-before-show anti-ghosting
// and frame-synchronous double-buffered display data.
module seven_seg_scan_ctrl #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*N_DIGITS-1:0]   wr_data,
  input  logic [N_DIGITS-1:0]     wr_dp,
  output logic [7:0]              seg_n,
  output logic [N_DIGITS-1:0]     dig_n,
  output logic                    frame_done
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(N_DIGITS);
  localparam int unsigned DATA_W = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                frame_end_c;
  logic                commit_c;
  logic [DATA_W-1:0]   active_data, shadow_data;
  logic [N_DIGITS-1:0] active_dp, shadow_dp;
  logic [7:0]          seg_nx;
  logic [N_DIGITS-1:0] dig_nx;
  logic [3:0]          nib_c;

  // Active-low g..a pattern for one hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Next-state, slot timing and next-output decode
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    cnt_nx      = cnt;
    frame_end_c = 1'b0;
    seg_nx      = 8'hFF;
    dig_nx      = '1;
    nib_c       = 4'h0;

    if (!en) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        BLANK: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BLANK_CYC - 1)) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            if (idx == IDX_W'(N_DIGITS - 1)) begin
              idx_nx      = '0;
              frame_end_c = 1'b1;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end

    // Active data cannot change while a digit is lit, so decode from it directly
    if (state_nx == SHOW) begin
      nib_c  = active_data[{idx_nx, 2'b00} +: 4];
      seg_nx = {~active_dp[idx_nx], hex_decode(nib_c)};
      dig_nx = ~(N_DIGITS'(1) << idx_nx);
    end
  end

  // Pending shadow data lands only between frames or while idle
  assign commit_c = !wr_ready && ((state == IDLE) || frame_end_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      seg_n       <= 8'hFF;
      dig_n       <= '1;
      frame_done  <= 1'b0;
      wr_ready    <= 1'b1;
      active_data <= '0;
      active_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      seg_n      <= seg_nx;
      dig_n      <= dig_nx;
      frame_done <= frame_end_c;
      if (commit_c) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        wr_ready    <= 1'b1;
      end else if (wr_valid && wr_ready) begin
        shadow_data <= wr_data;
        shadow_dp   <= wr_dp;
        wr_ready    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a time-arithmetic display model
// predicts every cycle's outputs; a monitor compares them at the falling edge.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 20;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seven_seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .seg_n(seg_n), .dig_n(dig_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: run = cycles since the scan started (-1 when idle)
  int          run;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_adp, m_sdp;
  logic        m_ready, m_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   d;
    logic [3:0] nib;
    logic [7:0] h;
    e.seg = 8'hFF;
    e.dig = 4'hF;
    e.fd  = m_fd;
    e.rdy = m_ready;
    if (run >= 0 && (run % SD) >= BL) begin
      d     = (run / SD) % N;
      nib   = m_active[4*d +: 4];
      h     = hex_tbl[nib];
      e.dig = ~(4'b0001 << d);
      e.seg = {~m_adp[d], h[6:0]};
    end
    return e;
  endfunction

  // Reference model: updates on every clock edge and on async reset
  initial begin
    bit prev_idle;
    run = -1; m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0;
    m_ready = 1'b1; m_fd = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run = -1; m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0;
        m_ready = 1'b1; m_fd = 1'b0;
        q.delete();
      end else begin
        prev_idle = (run < 0);
        run  = en ? run + 1 : -1;
        m_fd = en && run > 0 && (run % (N*SD)) == 0;
        if (!m_ready && (prev_idle || m_fd)) begin
          m_active = m_shadow; m_adp = m_sdp; m_ready = 1'b1;
        end else if (wr_valid && m_ready) begin
          m_shadow = wr_data; m_sdp = wr_dp; m_ready = 1'b0;
        end
      end
      q.push_back(model_out());
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_seg_n", 32'(seg_n), 32'(e.seg));
        chk("mon_dig_n", 32'(dig_n), 32'(e.dig));
        chk("mon_frame_done", 32'(frame_done), 32'(e.fd));
        chk("mon_wr_ready", 32'(wr_ready), 32'(e.rdy));
      end
    end
  end

  // Called at a falling edge; holds wr_valid until the handshake edge passes
  task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input int budget,
                          output int waited, output logic fd_at_accept);
    waited = 0;
    fd_at_accept = 1'b0;
    wr_valid = 1'b1; wr_data = d; wr_dp = dp;
    while (!wr_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) begin
      wr_valid = 1'b0;
      timeout_fail("write_accept");
    end else begin
      fd_at_accept = frame_done;
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_digit(input logic [3:0] d, input int budget, output logic [7:0] seg);
    seg = 8'hFF;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dig_n == d) begin
        seg = seg_n;
        return;
      end
    end
    timeout_fail("wait_digit");
  endtask

  task automatic wait_lit(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (dig_n != 4'hF) return;
    end
    timeout_fail("wait_lit");
  endtask

  initial begin
    int         n_fd, first_lit, w, n;
    logic       f;
    logic [7:0] s;
    logic [3:0] dsel;

    // Reset then free-running scan of zeros
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_seg_n", 32'(seg_n), 32'hFF);
    chk("reset_dig_n", 32'(dig_n), 32'hF);
    chk("reset_wr_ready", 32'(wr_ready), 32'h1);
    rst_n = 1'b1;
    n_fd = 0; first_lit = 0;
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      if (frame_done) n_fd++;
      if (first_lit == 0 && dig_n != 4'hF) first_lit = k;
    end
    chk("first_lit_cycle", 32'(first_lit), 32'(BL + 1));
    chk("frame_done_count", 32'(n_fd), 32'd2);
    for (int k = 0; k < N; k++) begin
      dsel = ~(4'b0001 << k);
      wait_digit(dsel, 200, s);
      chk("zero_frame_seg", 32'(s), 32'hC0);
    end

    // Mid-frame write, committed at the next frame boundary
    repeat (30) @(negedge clk);
    do_write(16'h3A0F, 4'b0010, 5, w, f);
    chk("wr1_wait", 32'(w), 32'd0);
    chk("wr1_ready_drop", 32'(wr_ready), 32'd0);
    n = 0;
    while (!frame_done && n < 200) begin @(negedge clk); n++; end
    if (!frame_done) timeout_fail("wr1_commit");
    chk("wr1_ready_back", 32'(wr_ready), 32'd1);
    wait_digit(4'hE, 200, s); chk("wr1_d0", 32'(s), 32'h8E);
    wait_digit(4'hD, 200, s); chk("wr1_d1", 32'(s), 32'h40);
    wait_digit(4'hB, 200, s); chk("wr1_d2", 32'(s), 32'h88);
    wait_digit(4'h7, 200, s); chk("wr1_d3", 32'(s), 32'hB0);

    // Second write while pending waits for the commit
    do_write(16'h1234, 4'b0001, 5, w, f);
    do_write(16'h5678, 4'b1000, 200, w, f);
    chk("wr2_blocked", 32'(w > 0), 32'd1);
    chk("wr2_accept_at_fd", 32'(f), 32'd1);
    repeat (2 * N * SD) @(negedge clk);

    // Drop enable during digit 2, then restart
    wait_digit(4'hB, 200, s);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_seg_n", 32'(seg_n), 32'hFF);
    chk("en_off_dig_n", 32'(dig_n), 32'hF);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_lit(100, n);
    chk("en_on_lit_cycle", 32'(n), 32'(BL + 1));
    chk("en_on_digit0", 32'(dig_n), 32'hE);

    // Async reset mid-SHOW discards pending data
    repeat (N * SD) @(negedge clk);
    do_write(16'hFFFF, 4'hF, 200, w, f);
    wait_lit(100, n);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg_n", 32'(seg_n), 32'hFF);
    chk("arst_dig_n", 32'(dig_n), 32'hF);
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_digit(4'hE, 200, s); chk("arst_after_d0", 32'(s), 32'hC0);
    wait_digit(4'h7, 200, s); chk("arst_after_d3", 32'(s), 32'hC0);

    // Write while disabled commits in IDLE
    en = 1'b0;
    repeat (3) @(negedge clk);
    do_write(16'hABCD, 4'b0101, 5, w, f);
    chk("idle_wr_pending", 32'(wr_ready), 32'd0);
    @(negedge clk);
    chk("idle_wr_commit", 32'(wr_ready), 32'd1);
    en = 1'b1;
    wait_digit(4'hE, 200, s); chk("idle_wr_d0", 32'(s), 32'h21);
    wait_digit(4'hD, 200, s); chk("idle_wr_d1", 32'(s), 32'hC6);

    // Randomised writes and enable drops
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      case ($urandom_range(0, 2))
        0, 1: do_write(16'($urandom), 4'($urandom), 400, w, f);
        default: begin
          en = 1'b0;
          repeat ($urandom_range(1, 10)) @(negedge clk);
          en = 1'b1;
        end
      endcase
    end
    repeat (2 * N * SD) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
